// File: rtl/fir_pipe_param.sv
// Pipelined direct-form FIR: stage 0 registers per-tap products, stage 1 registers the
// (optionally saturated) sum. Coefficients are run-time writable and survive flush.
module fir_pipe_param #(
  parameter int                        TAPS      = 5,
  parameter int                        SAMPLE_W  = 6,
  parameter int                        COEF_W    = 5,
  parameter int                        ACC_W     = SAMPLE_W + COEF_W + 3,
  parameter bit                        SATURATE  = 1'b1,
  parameter logic [TAPS*COEF_W-1:0]    COEF_INIT = {5'd3, 5'd7, 5'd20, 5'd7, 5'd3}
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  input  logic [SAMPLE_W-1:0]      in_data_i,
  input  logic                     flush_i,
  input  logic                     coef_we_i,
  input  logic [$clog2(TAPS)-1:0]  coef_addr_i,
  input  logic [COEF_W-1:0]        coef_data_i,
  output logic                     out_valid_o,
  output logic [ACC_W-1:0]         out_data_o
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = SAMPLE_W + COEF_W;
  localparam int SUM_W  = PROD_W + $clog2(TAPS);
  localparam bit ADDR_FULL = ((2 ** AW) == TAPS);
  localparam logic [AW-1:0] TAPS_A = AW'(TAPS);

  logic [COEF_W-1:0]   coef_q [TAPS];
  logic [COEF_W-1:0]   coef_d [TAPS];
  logic [SAMPLE_W-1:0] dly_q  [1:TAPS-1];
  logic [SAMPLE_W-1:0] dly_d  [1:TAPS-1];
  logic [PROD_W-1:0]   prod_q [TAPS];
  logic [PROD_W-1:0]   prod_d [TAPS];
  logic                p_valid_q, p_valid_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    out_data_q, out_data_d;

  logic [SUM_W-1:0]    sum;
  logic [ACC_W-1:0]    fit_val;
  logic                addr_ok;

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + SUM_W'(prod_q[k]);
    end
  end

  // Any bit above ACC_W set means the full-precision sum does not fit.
  always_comb begin
    if (SATURATE && ((sum >> ACC_W) != '0)) begin
      fit_val = '1;
    end else begin
      fit_val = ACC_W'(sum);
    end
  end

  assign addr_ok = ADDR_FULL || (coef_addr_i < TAPS_A);

  always_comb begin
    coef_d      = coef_q;
    dly_d       = dly_q;
    prod_d      = prod_q;
    p_valid_d   = 1'b0;
    out_valid_d = p_valid_q;
    out_data_d  = out_data_q;

    if (in_valid_i) begin
      prod_d[0] = PROD_W'(coef_q[0]) * PROD_W'(in_data_i);
      for (int k = 1; k < TAPS; k++) begin
        prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(dly_q[k]);
      end
      dly_d[1] = in_data_i;
      for (int k = 2; k < TAPS; k++) begin
        dly_d[k] = dly_q[k-1];
      end
      p_valid_d = 1'b1;
    end

    if (p_valid_q) begin
      out_data_d = fit_val;
    end

    // Products above were formed with coef_q, so a same-edge write only affects later samples.
    if (coef_we_i && addr_ok) begin
      coef_d[coef_addr_i] = coef_data_i;
    end

    if (flush_i) begin
      dly_d       = '{default: '0};
      prod_d      = '{default: '0};
      p_valid_d   = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end
      dly_q       <= '{default: '0};
      prod_q      <= '{default: '0};
      p_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      coef_q      <= coef_d;
      dly_q       <= dly_d;
      prod_q      <= prod_d;
      p_valid_q   <= p_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_fir_pipe_param.sv
// Bench for fir_pipe_param: a saturating and a wrapping instance share one stimulus and
// are checked each cycle against a sample-history model plus literal output sequences.
module tb_fir_pipe_param;

  localparam int TAPS = 5;
  localparam int ACCW = 12;
  localparam int AMAX = (1 << ACCW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [5:0]  id = '0;
  logic        flush = 1'b0;
  logic        cwe = 1'b0;
  logic [2:0]  ca = '0;
  logic [4:0]  cd = '0;
  logic        ov_s, ov_w;
  logic [11:0] od_s, od_w;

  int n_cmp = 0;
  int n_err = 0;
  int got_s[$];
  int got_w[$];

  always #5 clk = ~clk;

  fir_pipe_param #(.TAPS(TAPS), .SAMPLE_W(6), .COEF_W(5), .ACC_W(ACCW), .SATURATE(1'b1)) dut_sat (
    .clock_i(clk), .reset_i(rst), .in_valid_i(iv), .in_data_i(id), .flush_i(flush),
    .coef_we_i(cwe), .coef_addr_i(ca), .coef_data_i(cd),
    .out_valid_o(ov_s), .out_data_o(od_s));

  fir_pipe_param #(.TAPS(TAPS), .SAMPLE_W(6), .COEF_W(5), .ACC_W(ACCW), .SATURATE(1'b0)) dut_wrap (
    .clock_i(clk), .reset_i(rst), .in_valid_i(iv), .in_data_i(id), .flush_i(flush),
    .coef_we_i(cwe), .coef_addr_i(ca), .coef_data_i(cd),
    .out_valid_o(ov_w), .out_data_o(od_w));

  // Model: history of accepted samples, coefficient table, and a two-deep result pipe.
  const int dflt[TAPS] = '{3, 7, 20, 7, 3};
  int m_hist[TAPS-1];
  int m_coef[TAPS];
  bit m_pv = 1'b0;
  bit m_ov = 1'b0;
  int m_psum = 0;
  int m_od = 0;

  function automatic int fit_s(int s);
    return (s > AMAX) ? AMAX : s;
  endfunction

  function automatic int fit_w(int s);
    return s % (AMAX + 1);
  endfunction

  always @(posedge clk) begin
    int s;
    bit n_pv, n_ov;
    int n_od;
    if (rst) begin
      for (int k = 0; k < TAPS-1; k++) m_hist[k] = 0;
      for (int k = 0; k < TAPS; k++) m_coef[k] = dflt[k];
      m_pv = 1'b0; m_ov = 1'b0; m_od = 0; m_psum = 0;
    end else begin
      n_ov = m_pv;
      n_od = m_pv ? m_psum : m_od;
      n_pv = 1'b0;
      if (iv) begin
        s = m_coef[0] * int'(id);
        for (int k = 1; k < TAPS; k++) s += m_coef[k] * m_hist[k-1];
        for (int k = TAPS-2; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = int'(id);
        m_psum = s;
        n_pv = 1'b1;
      end
      if (cwe && int'(ca) < TAPS) m_coef[ca] = int'(cd);
      if (flush) begin
        for (int k = 0; k < TAPS-1; k++) m_hist[k] = 0;
        n_pv = 1'b0; n_ov = 1'b0; n_od = 0;
      end
      m_pv = n_pv; m_ov = n_ov; m_od = n_od;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid_sat", int'(ov_s), int'(m_ov));
    chk("out_data_sat", int'(od_s), fit_s(m_od));
    chk("out_valid_wrap", int'(ov_w), int'(m_ov));
    chk("out_data_wrap", int'(od_w), fit_w(m_od));
    if (ov_s) got_s.push_back(int'(od_s));
    if (ov_w) got_w.push_back(int'(od_w));
  end

  task automatic step(input bit v, input int d, input bit we = 1'b0, input int a = 0,
                      input int c = 0, input bit fl = 1'b0, input bit rs = 1'b0);
    iv = v; id = 6'(d); cwe = we; ca = 3'(a); cd = 5'(c); flush = fl; rst = rs;
    @(negedge clk);
    #1;
    iv = 1'b0; id = '0; cwe = 1'b0; ca = '0; cd = '0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic impulse5();
    step(1'b1, 1);
    repeat (4) step(1'b1, 0);
    repeat (3) step(1'b0, 0);
  endtask

  task automatic check_seq(input string name, input int n, input int es[6], input int ew[6]);
    chk({name, "_count_sat"}, got_s.size(), n);
    chk({name, "_count_wrap"}, got_w.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_s.size()) chk($sformatf("%s_sat[%0d]", name, i), got_s[i], es[i]);
      if (i < got_w.size()) chk($sformatf("%s_wrap[%0d]", name, i), got_w[i], ew[i]);
    end
    got_s.delete();
    got_w.delete();
  endtask

  initial begin
    repeat (4) step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("reset_valid", int'(ov_s), 0);
    chk("reset_data", int'(od_s), 0);
    got_s.delete(); got_w.delete();

    // Impulse, with explicit latency pinning
    step(1'b1, 1);
    chk("lat_edge0_valid", int'(ov_s), 0);
    step(1'b1, 0);
    chk("lat_edge1_valid", int'(ov_s), 1);
    chk("lat_edge1_data", int'(od_s), 3);
    repeat (4) step(1'b1, 0);
    repeat (3) step(1'b0, 0);
    check_seq("impulse", 6, '{3, 7, 20, 7, 3, 0}, '{3, 7, 20, 7, 3, 0});

    repeat (5) step(1'b1, 10);
    repeat (3) step(1'b0, 0);
    check_seq("step", 5, '{30, 100, 300, 370, 400, 0}, '{30, 100, 300, 370, 400, 0});

    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1);
    step(1'b0, 55);
    repeat (4) begin
      step(1'b1, 0);
      step(1'b0, 55);
    end
    repeat (3) step(1'b0, 55);
    check_seq("gapped", 5, '{3, 7, 20, 7, 3, 0}, '{3, 7, 20, 7, 3, 0});

    step(1'b0, 0, 1'b1, 2, 0);
    impulse5();
    check_seq("coef_wr2", 5, '{3, 7, 0, 7, 3, 0}, '{3, 7, 0, 7, 3, 0});
    step(1'b0, 0, 1'b1, 7, 31);
    impulse5();
    check_seq("coef_wr_oob", 5, '{3, 7, 0, 7, 3, 0}, '{3, 7, 0, 7, 3, 0});

    step(1'b1, 1, 1'b1, 0, 31);
    repeat (4) step(1'b1, 0);
    repeat (3) step(1'b0, 0);
    check_seq("same_edge", 5, '{3, 7, 0, 7, 3, 0}, '{3, 7, 0, 7, 3, 0});
    impulse5();
    check_seq("after_same_edge", 5, '{31, 7, 0, 7, 3, 0}, '{31, 7, 0, 7, 3, 0});

    for (int a = 0; a < TAPS; a++) step(1'b0, 0, 1'b1, a, 31);
    repeat (5) step(1'b1, 63);
    repeat (3) step(1'b0, 0);
    check_seq("saturate", 5, '{1953, 3906, 4095, 4095, 4095, 0},
              '{1953, 3906, 1763, 3716, 1573, 0});

    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (4) step(1'b1, 10);
    step(1'b1, 10, 1'b0, 0, 0, 1'b1);
    chk("flush_valid", int'(ov_s), 0);
    chk("flush_data", int'(od_s), 0);
    chk("flush_data_wrap", int'(od_w), 0);
    got_s.delete(); got_w.delete();
    step(1'b1, 10);
    repeat (3) step(1'b0, 0);
    check_seq("post_flush", 1, '{30, 0, 0, 0, 0, 0}, '{30, 0, 0, 0, 0, 0});

    step(1'b0, 0, 1'b1, 2, 0, 1'b1);
    impulse5();
    check_seq("flush_with_write", 5, '{3, 7, 0, 7, 3, 0}, '{3, 7, 0, 7, 3, 0});

    repeat (3) step(1'b1, 10);
    step(1'b1, 10, 1'b1, 1, 0, 1'b0, 1'b1);
    chk("midreset_valid", int'(ov_s), 0);
    chk("midreset_data", int'(od_s), 0);
    got_s.delete(); got_w.delete();
    repeat (2) step(1'b0, 0);
    chk("midreset_drained", got_s.size(), 0);
    impulse5();
    check_seq("post_reset", 5, '{3, 7, 20, 7, 3, 0}, '{3, 7, 20, 7, 3, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_pipe_param.md
# fir_pipe_param

Parametrised, pipelined direct-form FIR filter with a registered-product stage, sample-valid handshake, run-time loadable coefficients, flush, and optional output saturation. It is the next generation of the fixed 5-tap unsigned FIR filters in the programmable-logic lab designs. It sits between a sample source that may pause (non-contiguous in_valid) and a downstream consumer that qualifies data with out_valid.

## Interface
- TAPS, 5: number of coefficients; the delay line holds TAPS-1 past samples.
- SAMPLE_W, 6: unsigned sample width.
- COEF_W, 5: unsigned coefficient width.
- ACC_W, SAMPLE_W+COEF_W+3: out_data width.
- SATURATE, 1: 1 clamps an overflowing sum to all-ones; 0 keeps the low ACC_W bits.
- COEF_INIT, {5'd3,5'd7,5'd20,5'd7,5'd3}: reset coefficients, TAPS*COEF_W bits; tap k is at [k*COEF_W +: COEF_W].
- clock  in  1  the single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data is accepted on this edge.
- in_data  in  SAMPLE_W  sample x[n].
- flush  in  1  synchronous clear of the datapath; coefficients are kept.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index to write.
- coef_data  in  COEF_W  new coefficient value.
- out_valid  out  1  out_data holds a new result this cycle.
- out_data  out  ACC_W  y[n] = sum over k of b_k * x[n-k].

## Operation
- Stage 0, edge with in_valid=1:
  - prod[0] <= b0*in_data; prod[k] <= b_k*dly[k] for k=1..TAPS-1.
  - Delay line shifts: dly[1] <= in_data; dly[k] <= dly[k-1].
  - p_valid <= 1.
- Stage 0, edge with in_valid=0: delay line and prod hold; p_valid <= 0.
- Stage 1, edge with p_valid=1:
  - out_data <= fit(sum of prod[0..TAPS-1]).
  - The sum is full precision, SAMPLE_W+COEF_W+clog2(TAPS) bits.
- Stage 1, edge with p_valid=0: out_data holds. out_valid <= p_valid on every edge.
- fit():
  - SATURATE=1: if the sum is at least 2^ACC_W, the result is 2^ACC_W-1; otherwise the sum.
  - SATURATE=0: sum[ACC_W-1:0].
- All arithmetic is unsigned.
- Past samples count only accepted samples. Gaps in in_valid do not insert zeros.
- Coefficient write: an edge with coef_we=1 and coef_addr<TAPS sets b[coef_addr] <= coef_data. A write with coef_addr>=TAPS is ignored.
- The new coefficient applies to products formed on later edges. If a write and in_valid occur on the same edge, that edge's product uses the old value.
- Samples already in prod keep the coefficient they were multiplied with.
- flush: on an edge with flush=1, dly, prod, p_valid, out_valid and out_data are cleared to 0. in_valid on that edge is ignored. Coefficients are not affected.
- If coef_we and flush occur on the same edge, the coefficient write still happens.
- Priority: reset > flush > normal operation.

## Timing
- Reset, including assertion mid-stream, takes effect on the next edge:
  - out_data=0, out_valid=0, p_valid=0, all dly=0, all prod=0.
  - b = COEF_INIT.
  - In-flight results are discarded. in_valid and coef_we are ignored while reset=1.
- Latency: a sample accepted at edge E produces out_valid=1 with its result in the cycle after edge E+1. out_valid is in_valid delayed by 2 cycles.
- Throughput: one sample per clock; back-to-back in_valid is supported.
- out_valid is a single-cycle pulse per accepted sample.
- There is no backpressure: the downstream consumer must accept every out_valid.
- The first sample after reset or flush sees zeros in the delay line.

## Test plan
- Impulse response, default coefficients: hold reset for 4 cycles, then in_valid=1 with in_data 1,0,0,0,0,0 on consecutive cycles. Required out_data on the out_valid cycles: 3,7,20,7,3,0. The first out_valid comes 2 cycles after the first in_valid.
- Step input: 10 on 5 consecutive valid cycles. Required outputs 30,100,300,370,400.
- Gapped input: repeat the impulse test with in_valid high only on alternate cycles (idle cycles carry in_data=55). Required: the same values 3,7,20,7,3. out_valid mirrors in_valid delayed by 2 cycles, and out_data holds between pulses.
- Coefficient write: write coef_addr=2, coef_data=0, then apply an impulse. Required 3,7,0,7,3. Then write coef_addr=7 with TAPS=5: no change.
- Same-edge write: write coef_addr=0, coef_data=31 on the same edge as in_valid with in_data 1. Required first output 3, not 31.
- Saturation, with ACC_W=12 and all coefficients written to 31: feed 63 on 5 consecutive valid cycles.
  - Required outputs 1953, 3906, then 4095, 4095, 4095 (true sums 5859, 7812, 9765).
  - With SATURATE=0 the last three outputs are 5859 mod 4096 = 1763, 3716, and 9765 mod 4096 = 1573.
- Flush and reset mid-stream: feed steady 10s, then pulse flush.
  - Required next edge: out_valid=0 and out_data=0.
  - The next accepted 10 yields 30, proving the delay line was cleared.
  - After reset, coefficients read back as COEF_INIT, so an impulse gives 3,7,20,7,3.
